// File: rtl/sw_pkg.sv
//------------------------------------------------------------------------------
// Module   : sw_pkg
// Brief    : Shared defaults and helpers for the switch debouncer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sw_pkg;

    localparam int SW_WIDTH        = 32;
    localparam int SW_TICK_DIV     = 50_000;
    localparam int SW_STABLE_TICKS = 4;

    // Counter width able to hold the value n (0..n inclusive).
    function automatic int sw_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : sw_pkg

`default_nettype wire

// File: rtl/sw_debounce_bit.sv
//------------------------------------------------------------------------------
// Module   : sw_debounce_bit
// Brief    : One switch bit: 2-flop synchronizer, tick-qualified stability
//            counter and registered debounced level / change flag.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_tick,
    input  logic i_sw_raw,
    output logic o_sw_data,
    output logic o_update,
    output logic o_changed
);

    localparam int                c_CNT_W = sw_cnt_w(STABLE_TICKS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(STABLE_TICKS - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_data;
    logic               r_changed;

    logic               w_differs;
    logic               w_update;

    assign w_differs = (r_sync != r_data);
    // The final qualifying tick updates the output directly instead of
    // incrementing, so the counter never needs to reach STABLE_TICKS.
    assign w_update  = w_differs && i_tick && (r_cnt == c_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_cnt     <= '0;
            r_data    <= 1'b0;
            r_changed <= 1'b0;
        end else begin
            r_meta    <= i_sw_raw;
            r_sync    <= r_meta;
            r_changed <= w_update;
            if (w_update) begin
                r_data <= r_sync;
                r_cnt  <= '0;
            end else if (w_differs) begin
                if (i_tick) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_sw_data = r_data;
    assign o_update  = w_update;
    assign o_changed = r_changed;

endmodule : sw_debounce_bit

`default_nettype wire

// File: rtl/sw_debounce.sv
//------------------------------------------------------------------------------
// Module   : sw_debounce
// Brief    : WIDTH-bit switch debouncer with a shared free-running sample tick.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH        = SW_WIDTH,
    parameter int TICK_DIV     = SW_TICK_DIV,
    parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_sw_raw,
    output logic [WIDTH-1:0] o_sw_data,
    output logic             o_sw_changed,
    output logic [WIDTH-1:0] o_change_mask
);

    localparam int                 c_TICK_W = $clog2(TICK_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_tick;
    logic [WIDTH-1:0]    w_update;
    logic                r_sw_changed;

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // Summary flag is registered from the same update terms as the per-bit
    // change flags, so it lines up with o_change_mask.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_changed <= |w_update;
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            sw_debounce_bit #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_bit (
                .i_clk     (i_clk),
                .i_reset   (i_reset),
                .i_tick    (w_tick),
                .i_sw_raw  (i_sw_raw[g]),
                .o_sw_data (o_sw_data[g]),
                .o_update  (w_update[g]),
                .o_changed (o_change_mask[g])
            );
        end
    endgenerate

    assign o_sw_changed = r_sw_changed;

endmodule : sw_debounce

`default_nettype wire

// File: tb/tb_sw_debounce.sv
//------------------------------------------------------------------------------
// Module   : tb_sw_debounce
// Brief    : Directed self-checking bench for sw_debounce (WIDTH=4, TICK_DIV=4,
//            STABLE_TICKS=3).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sw_debounce;

    localparam int c_WIDTH = 4;

    logic               clk;
    logic               rst;
    logic [c_WIDTH-1:0] sw_raw;
    logic [c_WIDTH-1:0] sw_data;
    logic               sw_changed;
    logic [c_WIDTH-1:0] change_mask;

    int n_compared   = 0;
    int n_mismatched = 0;
    logic seen_changed;

    sw_debounce #(
        .WIDTH        (c_WIDTH),
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_sw_raw      (sw_raw),
        .o_sw_data     (sw_data),
        .o_sw_changed  (sw_changed),
        .o_change_mask (change_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] d,
                             input logic c, input logic [3:0] m);
        check({tag, ".data"}, 32'(sw_data), 32'(d));
        check({tag, ".chg"},  32'(sw_changed), 32'(c));
        check({tag, ".mask"}, 32'(change_mask), 32'(m));
    endtask

    initial begin
        rst    = 1'b1;
        sw_raw = 4'hF;

        // Reset held with all switches high
        step(1);
        check_out("rst1", 4'h0, 1'b0, 4'h0);
        step(3);
        check_out("rst2", 4'h0, 1'b0, 4'h0);

        // Clean press: release (edge E1 is first with reset low); ticks at E4, E8, E12
        rst    = 1'b0;
        sw_raw = 4'h1;
        step(11);
        check_out("press_pre", 4'h0, 1'b0, 4'h0);
        step(1);
        check_out("press_upd", 4'h1, 1'b1, 4'h1);
        step(1);
        check_out("press_post", 4'h1, 1'b0, 4'h0);

        // Glitch on bit 1 for 6 cycles: qualifies only 2 ticks (E16, E20)
        sw_raw       = 4'h3;
        seen_changed = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            seen_changed = seen_changed | sw_changed;
        end
        sw_raw = 4'h1;
        for (int i = 0; i < 13; i++) begin
            step(1);
            seen_changed = seen_changed | sw_changed;
        end
        check("glitch.data", 32'(sw_data), 32'h1);
        check("glitch.nochg", 32'(seen_changed), 32'h0);

        // Release bit 0 back to all-zero (update at E44)
        sw_raw = 4'h0;
        step(11);
        check("rel0_pre.data", 32'(sw_data), 32'h1);
        step(1);
        check_out("rel0_upd", 4'h0, 1'b1, 4'h1);

        // Simultaneous 0 -> A (update at E56)
        sw_raw = 4'hA;
        step(11);
        check_out("simul_pre", 4'h0, 1'b0, 4'h0);
        step(1);
        check_out("simul_upd", 4'hA, 1'b1, 4'hA);
        step(1);
        check_out("simul_post", 4'hA, 1'b0, 4'h0);

        // Release bit 3: A -> 2 (update at E68)
        sw_raw = 4'h2;
        step(10);
        check("rel_pre.data", 32'(sw_data), 32'hA);
        step(1);
        check_out("rel_upd", 4'h2, 1'b1, 4'h8);

        // Reset after 2 qualifying ticks (E72, E76) of bit 0
        sw_raw = 4'h3;
        step(9);
        rst = 1'b1;
        #1;
        check_out("midrst_async", 4'h0, 1'b0, 4'h0);
        step(2);
        check_out("midrst_hold", 4'h0, 1'b0, 4'h0);

        // After release, both bits need 3 fresh ticks (F4, F8, F12)
        rst = 1'b0;
        step(3);
        check_out("fresh_f3", 4'h0, 1'b0, 4'h0);
        step(8);
        check_out("fresh_f11", 4'h0, 1'b0, 4'h0);
        step(1);
        check_out("fresh_upd", 4'h3, 1'b1, 4'h3);
        step(1);
        check_out("fresh_post", 4'h3, 1'b0, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_sw_debounce

`default_nettype wire

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of switch bits conditioned.
REQ-002 The block SHALL have parameter TICK_DIV, default 50_000, giving the i_clk cycles per sample tick (legal range >= 2).
REQ-003 The block SHALL have parameter STABLE_TICKS, default 4, giving the consecutive ticks an input must differ before the output follows it (legal range >= 1).
REQ-004 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_sw_raw  input  WIDTH  asynchronous board switch levels.
REQ-007 o_sw_data  output  WIDTH  debounced switch levels; drives the core's i_io_sw.
REQ-008 o_sw_changed  output  1  single-cycle pulse marking a cycle in which o_sw_data changed.
REQ-009 o_change_mask  output  WIDTH  bits of o_sw_data that changed in the o_sw_changed cycle; zero otherwise.

Function
REQ-010 i_sw_raw SHALL pass through a 2-flop synchronizer per bit; only the second stage (sync) SHALL be used downstream.
REQ-011 A shared tick counter SHALL count 0..TICK_DIV-1, wrap to 0, and assert internal tick for exactly the one cycle in which count == TICK_DIV-1.
REQ-012 Each bit SHALL own a stability counter of width $clog2(STABLE_TICKS+1).
REQ-013 When sync[i] == o_sw_data[i], the bit counter SHALL clear at the next edge regardless of tick.
REQ-014 When sync[i] != o_sw_data[i] and tick is high, the bit counter SHALL increment.
REQ-015 When sync[i] != o_sw_data[i], tick is high, and the counter equals STABLE_TICKS-1, o_sw_data[i] SHALL take sync[i] at that edge and the counter SHALL clear.
REQ-016 A glitch that returns to the output level before the STABLE_TICKS-th differing tick SHALL leave o_sw_data unchanged and restart qualification from zero.
REQ-017 With STABLE_TICKS == 1, a bit SHALL update on the first tick at which it differs.
REQ-018 Bits SHALL be independent; several bits qualifying on the same tick SHALL update at the same edge.
REQ-019 o_sw_changed and o_change_mask SHALL be registered together with o_sw_data: high/non-zero only in the cycle right after the updating edge, then low/zero the next cycle unless another update occurs.
REQ-020 Tick counter behaviour SHALL NOT depend on input activity (free-running).

Reset
REQ-021 While i_reset is high, synchronizer stages, tick counter, bit counters, o_sw_data, o_sw_changed and o_change_mask SHALL all be 0.
REQ-022 Asserting i_reset mid-qualification SHALL discard all partial counts; after release, qualification SHALL start from zero counts and tick count 0.
REQ-023 The first tick after reset release SHALL occur TICK_DIV cycles after the first rising edge with i_reset low.

Structure
REQ-024 A shared package sw_pkg SHALL hold defaults SW_WIDTH=32, SW_TICK_DIV=50_000 and SW_STABLE_TICKS=4; the block parameters SHALL default to these constants.
REQ-025 Per-bit sync/count/update logic SHALL live in a sub-module sw_debounce_bit, instantiated WIDTH times by generate; the tick counter SHALL live in sw_debounce.
REQ-026 The block SHALL contain no latches and no combinational path from i_sw_raw to any output.

Verification (bench parameters WIDTH=4, TICK_DIV=4, STABLE_TICKS=3)
REQ-027 Reset: hold i_reset high with i_sw_raw=4'hF -> o_sw_data=0, o_sw_changed=0, o_change_mask=0 throughout.
REQ-028 Clean press: after reset release, set i_sw_raw=4'h1 and hold -> o_sw_data becomes 4'h1 on the 3rd tick after sync[0] rises; o_sw_changed pulses 1 cycle with o_change_mask=4'h1.
REQ-029 Glitch: raise bit 1 for 6 cycles (spanning 1-2 ticks), then drop it -> o_sw_data[1] stays 0 and o_sw_changed never pulses.
REQ-030 Simultaneous: from 4'h0, set i_sw_raw=4'hA at once -> a single o_sw_changed pulse with o_change_mask=4'hA and o_sw_data=4'hA.
REQ-031 Release: from o_sw_data=4'hA, drive i_sw_raw=4'h2 -> after 3 ticks o_sw_data=4'h2 and o_change_mask=4'h8.
REQ-032 Reset mid-operation: assert i_reset after 2 qualifying ticks, release, keep input high -> update needs 3 full fresh ticks from release; o_sw_data=0 until then.
